// File: rtl/fv_pingpong_bank_array.sv
// Banked ping/pong FV line store: lockstep stream from the read buffer, per-bank random reads, writes into the other buffer.
// Optional FV_CONFLICT_CNT_EN adds conflict_cnt, counting stream issues blocked by random reads.
module fv_pingpong_bank_array #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stream_begin,
  input  logic [ADDR_W-1:0]             stream_base,
  input  logic [ADDR_W:0]               stream_len,
  input  logic                          stream_ready,
  output logic                          stream_valid,
  output logic [NUM_BANKS*DATA_W-1:0]   stream_data,
  output logic                          stream_last,
  output logic                          stream_busy,
  input  logic [NUM_BANKS-1:0]          rd_req,
  input  logic [NUM_BANKS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_BANKS-1:0]          rd_valid,
  output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
  input  logic [NUM_BANKS-1:0]          wr_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   wr_data,
  input  logic                          swap_req,
  output logic                          buf_sel,
`ifdef FV_CONFLICT_CNT_EN
  output logic [15:0]                   conflict_cnt,
`endif
  output logic                          swap_pending
);

  // Stream handshake: a beat transfers on a cycle where stream_valid && stream_ready;
  // while stream_valid is high and stream_ready low, data and last are held unchanged.

  localparam int LINE_W = NUM_BANKS * DATA_W;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;
  logic [1:0]          skid_cnt_q, skid_cnt_d;
  logic [LINE_W-1:0]   skid0_q, skid0_d, skid1_q, skid1_d;
  logic                skid0_last_q, skid0_last_d, skid1_last_q, skid1_last_d;
  logic                buf_sel_q, buf_sel_d;
  logic                swap_pending_q, swap_pending_d;
  logic [NUM_BANKS-1:0] rd_valid_q, rd_valid_d;
  logic [LINE_W-1:0]   rdata_q;

  logic [DATA_W-1:0]   mem_a [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0]   mem_b [NUM_BANKS][DEPTH];

  logic                head_valid, head_last, pop, room, issue, rd_any;
  logic                consume_skid, push;
  logic [1:0]          cnt_tmp;
  logic [LINE_W-1:0]   head_data;

  // The registered memory output doubles as the front of the skid so a beat is visible one cycle after issue.
  always_comb begin
    head_valid = (skid_cnt_q != 2'd0) || inflight_q;
    head_data  = (skid_cnt_q != 2'd0) ? skid0_q : rdata_q;
    head_last  = (skid_cnt_q != 2'd0) ? skid0_last_q : inflight_last_q;
    pop        = head_valid && stream_ready;
    rd_any     = |rd_req;
    room       = (({1'b0, skid_cnt_q} + {2'b00, inflight_q}) < 3'd2) || pop;
    issue      = (state_q == ST_STREAM) && room && !rd_any;
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stream_begin && (stream_len != '0)) begin
          state_d     = ST_STREAM;
          addr_d      = stream_base;
          remaining_d = stream_len;
        end
      end
      ST_STREAM: begin
        if (issue) begin
          addr_d          = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          remaining_d     = remaining_q - 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = (remaining_q == CNT_W'(1));
          if (remaining_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    skid0_d      = skid0_q;
    skid1_d      = skid1_q;
    skid0_last_d = skid0_last_q;
    skid1_last_d = skid1_last_q;
    consume_skid = pop && (skid_cnt_q != 2'd0);
    push         = inflight_q && !(pop && (skid_cnt_q == 2'd0));
    cnt_tmp      = skid_cnt_q;
    if (consume_skid) begin
      skid0_d      = skid1_q;
      skid0_last_d = skid1_last_q;
      cnt_tmp      = skid_cnt_q - 2'd1;
    end
    skid_cnt_d = cnt_tmp;
    if (push) begin
      if (cnt_tmp == 2'd0) begin
        skid0_d      = rdata_q;
        skid0_last_d = inflight_last_q;
      end else begin
        skid1_d      = rdata_q;
        skid1_last_d = inflight_last_q;
      end
      skid_cnt_d = cnt_tmp + 2'd1;
    end
  end

  // A swap requested while busy is remembered and applied on the edge that returns the FSM to idle.
  always_comb begin
    buf_sel_d      = buf_sel_q;
    swap_pending_d = swap_pending_q;
    rd_valid_d     = rd_req;
    if (state_q == ST_IDLE) begin
      if (swap_req) buf_sel_d = ~buf_sel_q;
    end else if ((state_d == ST_IDLE) && (swap_pending_q || swap_req)) begin
      buf_sel_d      = ~buf_sel_q;
      swap_pending_d = 1'b0;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      skid_cnt_q      <= 2'd0;
      skid0_q         <= '0;
      skid1_q         <= '0;
      skid0_last_q    <= 1'b0;
      skid1_last_q    <= 1'b0;
      buf_sel_q       <= 1'b0;
      swap_pending_q  <= 1'b0;
      rd_valid_q      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      skid_cnt_q      <= skid_cnt_d;
      skid0_q         <= skid0_d;
      skid1_q         <= skid1_d;
      skid0_last_q    <= skid0_last_d;
      skid1_last_q    <= skid1_last_d;
      buf_sel_q       <= buf_sel_d;
      swap_pending_q  <= swap_pending_d;
      rd_valid_q      <= rd_valid_d;
    end
  end

  // Writes only ever land in the buffer that is not currently being read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en[b]) begin
        if (buf_sel_q) mem_a[b][wr_addr[b*ADDR_W +: ADDR_W]] <= wr_data[b*DATA_W +: DATA_W];
        else           mem_b[b][wr_addr[b*ADDR_W +: ADDR_W]] <= wr_data[b*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_req[b]) begin
          rdata_q[b*DATA_W +: DATA_W] <= buf_sel_q ? mem_b[b][rd_addr[b*ADDR_W +: ADDR_W]]
                                                   : mem_a[b][rd_addr[b*ADDR_W +: ADDR_W]];
        end else if (issue) begin
          rdata_q[b*DATA_W +: DATA_W] <= buf_sel_q ? mem_b[b][addr_q] : mem_a[b][addr_q];
        end
      end
    end
  end

`ifdef FV_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        blocked;

  always_comb begin
    blocked        = (state_q == ST_STREAM) && room && rd_any;
    conflict_cnt_d = conflict_cnt_q;
    if ((state_q == ST_IDLE) && stream_begin && (stream_len != '0)) conflict_cnt_d = 16'd0;
    else if (blocked && (conflict_cnt_q != 16'hFFFF))               conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) conflict_cnt_q <= 16'd0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

  assign stream_valid = head_valid;
  assign stream_data  = head_data;
  assign stream_last  = head_valid && head_last;
  assign stream_busy  = (state_q != ST_IDLE);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rdata_q;
  assign buf_sel      = buf_sel_q;
  assign swap_pending = swap_pending_q;

endmodule

// File: tb/tb_fv_pingpong_bank_array.sv
// Directed bench for fv_pingpong_bank_array: streaming, wrap, backpressure, random-read priority, swaps, reset.
module tb_fv_pingpong_bank_array;

  localparam int NB = 4;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int LW = NB * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stream_begin = 1'b0;
  logic [AW-1:0] stream_base = '0;
  logic [AW:0]   stream_len = '0;
  logic          stream_ready = 1'b0;
  logic          stream_valid;
  logic [LW-1:0] stream_data;
  logic          stream_last;
  logic          stream_busy;
  logic [NB-1:0] rd_req = '0;
  logic [NB*AW-1:0] rd_addr = '0;
  logic [NB-1:0] rd_valid;
  logic [LW-1:0] rd_data;
  logic [NB-1:0] wr_en = '0;
  logic [NB*AW-1:0] wr_addr = '0;
  logic [LW-1:0] wr_data = '0;
  logic          swap_req = 1'b0;
  logic          buf_sel;
  logic          swap_pending;
`ifdef FV_CONFLICT_CNT_EN
  logic [15:0]   conflict_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  logic [LW-1:0] exp_q[$];

  fv_pingpong_bank_array dut (
    .clk(clk), .reset(reset),
    .stream_begin(stream_begin), .stream_base(stream_base), .stream_len(stream_len),
    .stream_ready(stream_ready), .stream_valid(stream_valid), .stream_data(stream_data),
    .stream_last(stream_last), .stream_busy(stream_busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .buf_sel(buf_sel),
`ifdef FV_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .swap_pending(swap_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_val(input int a);
    logic [LW-1:0] v;
    for (int b = 0; b < NB; b++) v[b*DW +: DW] = 64'((b << 16) | a);
    return v;
  endfunction

  task automatic write_line(input int a);
    wr_en   = '1;
    wr_data = line_val(a);
    for (int b = 0; b < NB; b++) wr_addr[b*AW +: AW] = 8'(a);
    tick();
    wr_en = '0;
  endtask

  task automatic do_swap(input logic exp_sel);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_idle_buf_sel", 256'(buf_sel), 256'(exp_sel));
  endtask

  // Runs one stream; ready follows pat[cyc%8]; optional rd_req[2] window of 3 cycles and double swap request.
  task automatic run_stream(input int base, input int len, input logic [7:0] pat,
                            input int rd_start, input int swap_at, input int exp_done);
    int cyc, got, first, done;
    logic stalled;
    logic sel0;
    logic [LW-1:0] held;
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(line_val((base + k) % 256));
    sel0 = buf_sel;
    stream_base  = 8'(base);
    stream_len   = 9'(len);
    stream_begin = 1'b1;
    stream_ready = pat[0];
    tick();
    stream_begin = 1'b0;
    cyc = 1; got = 0; first = -1; done = -1; stalled = 1'b0; held = '0;
    while (got < len && cyc < 200) begin
      stream_ready = pat[cyc % 8];
      rd_addr  = {NB{8'd5}};
      rd_req   = (rd_start >= 0 && cyc >= rd_start && cyc < rd_start + 3) ? 4'b0100 : 4'b0000;
      swap_req = (swap_at >= 0 && (cyc == swap_at || cyc == swap_at + 2));
      if (rd_start >= 0) begin
        chk("rd_valid", 256'(rd_valid), (cyc > rd_start && cyc <= rd_start + 3) ? 256'h4 : 256'h0);
        if (rd_valid[2]) chk("rd_data_bank2", 256'(rd_data[2*DW +: DW]), 256'h20005);
      end
      if (swap_at >= 0) begin
        chk("buf_sel_held_busy", 256'(buf_sel), 256'(sel0));
        if (cyc > swap_at) chk("swap_pending", 256'(swap_pending), 256'h1);
      end
      if (stalled) begin
        chk("hold_valid", 256'(stream_valid), 256'h1);
        chk("hold_data", 256'(stream_data), 256'(held));
      end
      if (stream_valid && first < 0) first = cyc;
      stalled = 1'b0;
      if (stream_valid && stream_ready) begin
        chk("beat_data", 256'(stream_data), 256'(exp_q[0]));
        chk("beat_last", 256'(stream_last), 256'(exp_q.size() == 1));
        void'(exp_q.pop_front());
        got++;
        done = cyc;
      end else if (stream_valid) begin
        stalled = 1'b1;
        held = stream_data;
      end
      tick();
      cyc++;
    end
    rd_req   = '0;
    swap_req = 1'b0;
    chk("beats_received", 256'(got), 256'(len));
    chk("first_beat_cycle", 256'(first), 256'(2));
    if (exp_done >= 0) chk("last_pop_cycle", 256'(done), 256'(exp_done));
    chk("busy_after", 256'(stream_busy), 256'h0);
    chk("valid_after", 256'(stream_valid), 256'h0);
    chk("pending_after", 256'(swap_pending), 256'h0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 256'(stream_valid), 256'h0);
    chk("rst_data", 256'(stream_data), 256'h0);
    chk("rst_last", 256'(stream_last), 256'h0);
    chk("rst_busy", 256'(stream_busy), 256'h0);
    chk("rst_rd_valid", 256'(rd_valid), 256'h0);
    chk("rst_rd_data", 256'(rd_data), 256'h0);
    chk("rst_buf_sel", 256'(buf_sel), 256'h0);
    chk("rst_pending", 256'(swap_pending), 256'h0);

    // fill buffer B, swap it in, stream 8 lines at full rate
    for (int i = 0; i < 8; i++) write_line(i);
    do_swap(1'b1);
    run_stream(0, 8, 8'hFF, -1, -1, 9);

    // address wrap: fill A at 254,255,0,1 and stream from DEPTH-2
    write_line(254);
    write_line(255);
    write_line(0);
    write_line(1);
    do_swap(1'b0);
    run_stream(254, 4, 8'hFF, -1, -1, 5);
    do_swap(1'b1);

    // backpressure pattern 1,0,0,1
    run_stream(0, 8, 8'b1001_1001, -1, -1, -1);

    // random reads on bank 2 stall three issues
    run_stream(0, 8, 8'hFF, 3, -1, 12);
`ifdef FV_CONFLICT_CNT_EN
    chk("conflict_cnt", 256'(conflict_cnt), 256'h3);
`endif

    // two swap requests mid-stream collapse into one toggle at idle
    run_stream(0, 4, 8'hFF, -1, 2, -1);
    chk("swap_once_buf_sel", 256'(buf_sel), 256'h0);

    // zero-length begin produces nothing
    stream_len   = '0;
    stream_begin = 1'b1;
    tick();
    stream_begin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("len0_busy", 256'(stream_busy), 256'h0);
      chk("len0_valid", 256'(stream_valid), 256'h0);
      tick();
    end

    // reset mid-stream after three beats
    do_swap(1'b1);
    stream_base  = '0;
    stream_len   = 9'd8;
    stream_ready = 1'b1;
    stream_begin = 1'b1;
    tick();
    stream_begin = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("pre_reset_data", 256'(stream_data), 256'(line_val(i)));
      tick();
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 256'(stream_valid), 256'h0);
    chk("mid_rst_busy", 256'(stream_busy), 256'h0);
    chk("mid_rst_buf_sel", 256'(buf_sel), 256'h0);
    chk("mid_rst_pending", 256'(swap_pending), 256'h0);
    reset = 1'b0;
    tick();
    run_stream(254, 4, 8'hFF, -1, -1, 5);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fv_pingpong_bank_array.md
Name: fv_pingpong_bank_array

Overview:
- Parametrised successor to the per-bank big-FV memory wrapper.
- NUM_BANKS banks, each holding two physical buffers (ping/pong): a read buffer and a write buffer. The read buffer streams FV lines to the small-FV stage in lockstep across banks and serves per-bank random reads for edge PEs. The write buffer accepts updated FVs for the next replay iteration.
- The buffer roles swap on request, with the swap deferred until the block is idle.
- Adds behaviour the previous generation lacks: configurable width, depth and bank count; stream backpressure; explicit deferred swap.

Parameters:
- NUM_BANKS, 4, number of banks.
- DATA_W, 64, bits per FV line.
- DEPTH, 256, lines per buffer per bank.
- ADDR_W, $clog2(DEPTH), derived; not to be overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stream_begin  in  1  start-of-stream pulse
- stream_base  in  ADDR_W  first line address
- stream_len  in  ADDR_W+1  number of lines (0..DEPTH)
- stream_ready  in  1  consumer accepts the current beat
- stream_valid  out  1  stream beat valid (all banks)
- stream_data  out  NUM_BANKS*DATA_W  bank b in bits [b*DATA_W +: DATA_W]
- stream_last  out  1  final beat
- stream_busy  out  1  stream active (not IDLE)
- rd_req  in  NUM_BANKS  per-bank random read request
- rd_addr  in  NUM_BANKS*ADDR_W  random read addresses
- rd_valid  out  NUM_BANKS  random read data valid
- rd_data  out  NUM_BANKS*DATA_W  random read data
- wr_en  in  NUM_BANKS  per-bank write into the write buffer
- wr_addr  in  NUM_BANKS*ADDR_W  write addresses
- wr_data  in  NUM_BANKS*DATA_W  write data
- swap_req  in  1  request a ping/pong role swap
- buf_sel  out  1  0: buffer A is the read buffer, 1: buffer B is the read buffer
- swap_pending  out  1  swap accepted, not yet performed

Behaviour:
- Reset: all outputs 0, FSM IDLE, skid buffer empty, buf_sel=0, swap_pending=0. Reset mid-stream aborts the stream; in-flight reads are discarded.
- Memory: synchronous single-port arrays, read latency 1. Read buffer = buf_sel ? B : A; write buffer = the other. Writes never touch the read buffer, so same-cycle write plus read on one bank never conflicts.
- Random read: rd_req[b] issues a read of the read buffer; rd_valid[b]/rd_data[b] appear exactly 1 cycle later for 1 cycle. There is no backpressure.
- FSM states IDLE, STREAM, DRAIN:
  - IDLE to STREAM on stream_begin with stream_len>0. Latch addr=stream_base and remaining=stream_len.
  - stream_begin with stream_len=0: stay IDLE, no beats.
  - stream_begin outside IDLE is ignored.
- STREAM issue rule: in a cycle, issue one lockstep read at addr to all banks iff (skid_count + inflight) < 2, or a pop occurs this cycle, AND rd_req is all-zero. A random read has priority, so any rd_req bit stalls stream issue for that cycle.
- On issue: addr = (addr+1) mod DEPTH (wraps), remaining--. When remaining hits 0, go to DRAIN.
- Skid buffer: 2 entries. stream_valid = skid non-empty. Pop when stream_valid && stream_ready. Data and valid hold stable while stalled. stream_last is set on the beat carrying the final line.
- DRAIN to IDLE when the last beat pops.
- Swap:
  - swap_req in IDLE with no in-flight reads: buf_sel toggles on the next edge.
  - swap_req otherwise: swap_pending=1; the toggle happens on the edge the FSM returns to IDLE, and swap_pending clears then.
  - Multiple requests while pending collapse into one swap.
- Best-case stream: first beat valid 2 cycles after stream_begin; 1 beat/cycle throughput with stream_ready held high.

Optional Feature:
- Macro: FV_CONFLICT_CNT_EN.
- With it defined: add output conflict_cnt, 16 bits. It counts cycles in STREAM where an issue was blocked by rd_req, saturates at 0xFFFF, and clears on reset and on stream_begin accepted in IDLE.
- Without it: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then write line i value (b<<16|i) to all 4 banks, i=0..7. swap_req in IDLE, so buf_sel=1 next cycle. stream_begin base=0 len=8, ready=1 -> 8 consecutive beats with bank b = b<<16|i, stream_last on beat 7, first beat 2 cycles after begin.
- Stream with base=DEPTH-2, len=4 -> addresses 254, 255, 0, 1 in order.
- Toggle stream_ready 1,0,0,1 during a stream -> no beat lost or duplicated; data held during stalls.
- Assert rd_req[2] addr=5 for 3 cycles mid-stream -> rd_valid[2] with line 5 each following cycle; stream stalls 3 issues; conflict_cnt=3 when FV_CONFLICT_CNT_EN is defined.
- swap_req twice mid-stream -> swap_pending=1 and a single toggle of buf_sel at return to IDLE. stream_begin with len=0 -> no beat, stream_busy stays 0.
- Assert reset in STREAM after 3 beats -> next cycle stream_valid=0, buf_sel=0, FSM IDLE; a new stream restarts cleanly.
